leddc_scan_sched: RTL and testbench

Scan-line scheduler and SRAM port arbiter for the LED display controller. It steps through the scan lines of a frame and, for each line, fetches the 16 channel grey-scale words from the frame SRAM. It then runs the PWM display window that the output stage compares against. The frame SRAM has a single physical port, which the block shares between its own fetch traffic and the external refill writer that moves incoming DAI data into the SRAM.

---
 rtl/leddc_pkg.sv | 18 +
 rtl/leddc_sram_arb.sv | 36 +++
 rtl/leddc_scan_sched.sv | 163 ++++++++++++++++
 tb/tb_leddc_scan_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/leddc_pkg.sv
// Shared types and constants for the LED display scan-line scheduler.
package leddc_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, LOAD, DISPLAY} state_e;

   localparam int CH_PER_LINE    = 16;
   localparam int DEF_SCANLINES  = 32;
   localparam int DEF_PWM_CYCLES = 32;
   localparam int MAX_LINE_W     = 5;
   localparam int MAX_ADDR_W     = MAX_LINE_W + 4;

   // Frame SRAM word address: scan line in the upper bits, channel in the low nibble.
   function automatic logic [MAX_ADDR_W-1:0] compose_addr(input logic [MAX_LINE_W-1:0] line,
                                                          input logic [3:0]            ch);
      return {line, ch};
   endfunction

endpackage

// File: rtl/leddc_sram_arb.sv
// Single-port frame SRAM mux: line fetch has strict priority over the refill writer.
module leddc_sram_arb #(
   parameter int ADDR_W = 9
) (
   input  logic              fetch_issue_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   input  logic              wr_req_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [15:0]       wr_data_i,
   output logic              wr_gnt_o,
   output logic              ram_cen_o,
   output logic              ram_wen_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [15:0]       ram_din_o
);

   assign wr_gnt_o = wr_req_i & ~fetch_issue_i;

   always_comb begin
      // NOTE: every output gets a default first so no path through this block infers a latch.
      ram_cen_o  = 1'b1;
      ram_wen_o  = 1'b1;
      ram_addr_o = '0;
      ram_din_o  = '0;
      if (fetch_issue_i) begin
         ram_cen_o  = 1'b0;
         ram_addr_o = fetch_addr_i;
      end else if (wr_gnt_o) begin
         ram_cen_o  = 1'b0;
         ram_wen_o  = 1'b0;
         ram_addr_o = wr_addr_i;
         ram_din_o  = wr_data_i;
      end
   end

endmodule

// File: rtl/leddc_scan_sched.sv
// Scan-line scheduler: fetches 16 channel words per line, then runs the PWM display window(s).
module leddc_scan_sched
   import leddc_pkg::*;
#(
   parameter int SCANLINES  = DEF_SCANLINES,
   parameter int CHANNELS   = CH_PER_LINE,
   parameter int PWM_CYCLES = DEF_PWM_CYCLES,
   parameter int ADDR_W     = 9
) (
   input  logic                         GCK,
   input  logic                         rst,
   input  logic                         Vsync,
   input  logic                         mode,
   input  logic                         wr_req,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [15:0]                  wr_data,
   output logic                         wr_gnt,
   output logic                         ram_cen,
   output logic                         ram_wen,
   output logic [ADDR_W-1:0]            ram_addr,
   output logic [15:0]                  ram_din,
   output logic                         rd_valid,
   output logic [3:0]                   rd_ch,
   output logic                         pwm_load,
   output logic [4:0]                   pwm_cnt,
   output logic                         blank,
   output logic [$clog2(SCANLINES)-1:0] line_idx,
   output logic                         frame_done
);

   localparam int LINE_W = $clog2(SCANLINES);

   state_e            state_q, state_d;
   logic [3:0]        ch_q, ch_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [4:0]        cnt_q, cnt_d;
   logic              mode_q, mode_d;
   logic              win2_q, win2_d;
   logic              pwm_load_q, pwm_load_d;
   logic              frame_done_q, frame_done_d;
   logic              blank_q, blank_d;
   logic              rd_valid_q, rd_valid_d;
   logic [3:0]        rd_ch_q, rd_ch_d;

   logic              fetch_issue;
   logic [ADDR_W-1:0] fetch_addr;

   assign fetch_issue = (state_q == FETCH);
   assign fetch_addr  = ADDR_W'(compose_addr(MAX_LINE_W'(line_q), ch_q));

   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      line_d       = line_q;
      cnt_d        = cnt_q;
      mode_d       = mode_q;
      win2_d       = win2_q;
      pwm_load_d   = 1'b0;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: if (Vsync) begin
            state_d = FETCH;
            ch_d    = '0;
            line_d  = '0;
         end
         FETCH: begin
            ch_d = ch_q + 4'd1;
            if (ch_q == 4'(CHANNELS - 1)) begin
               state_d    = LOAD;
               pwm_load_d = 1'b1;
            end
         end
         LOAD: begin
            state_d = DISPLAY;
            cnt_d   = '0;
            mode_d  = mode;
            win2_d  = 1'b0;
         end
         DISPLAY: begin
            if (cnt_q == 5'(PWM_CYCLES - 1)) begin
               cnt_d = '0;
               if (mode_q && !win2_q) begin
                  win2_d = 1'b1;
               end else begin
                  state_d = FETCH;
                  ch_d    = '0;
                  if (line_q == LINE_W'(SCANLINES - 1)) begin
                     line_d       = '0;
                     frame_done_d = 1'b1;
                  end else begin
                     line_d = line_q + LINE_W'(1);
                  end
               end
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Vsync low aborts the frame; a completed frame still reports frame_done.
      if (!Vsync) begin
         state_d    = IDLE;
         ch_d       = '0;
         line_d     = '0;
         cnt_d      = '0;
         pwm_load_d = 1'b0;
      end
      blank_d    = (state_d != DISPLAY);
      rd_valid_d = fetch_issue;
      rd_ch_d    = ch_q;
   end

   always_ff @(posedge GCK or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         ch_q         <= '0;
         line_q       <= '0;
         cnt_q        <= '0;
         mode_q       <= 1'b0;
         win2_q       <= 1'b0;
         pwm_load_q   <= 1'b0;
         frame_done_q <= 1'b0;
         blank_q      <= 1'b1;
         rd_valid_q   <= 1'b0;
         rd_ch_q      <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values computed above.
         state_q      <= state_d;
         ch_q         <= ch_d;
         line_q       <= line_d;
         cnt_q        <= cnt_d;
         mode_q       <= mode_d;
         win2_q       <= win2_d;
         pwm_load_q   <= pwm_load_d;
         frame_done_q <= frame_done_d;
         blank_q      <= blank_d;
         rd_valid_q   <= rd_valid_d;
         rd_ch_q      <= rd_ch_d;
      end
   end

   leddc_sram_arb #(.ADDR_W(ADDR_W)) u_arb (
      .fetch_issue_i (fetch_issue),
      .fetch_addr_i  (fetch_addr),
      .wr_req_i      (wr_req),
      .wr_addr_i     (wr_addr),
      .wr_data_i     (wr_data),
      .wr_gnt_o      (wr_gnt),
      .ram_cen_o     (ram_cen),
      .ram_wen_o     (ram_wen),
      .ram_addr_o    (ram_addr),
      .ram_din_o     (ram_din)
   );

   assign pwm_load   = pwm_load_q;
   assign pwm_cnt    = cnt_q;
   assign blank      = blank_q;
   assign line_idx   = line_q;
   assign frame_done = frame_done_q;
   assign rd_valid   = rd_valid_q;
   assign rd_ch      = rd_ch_q;

endmodule

// File: tb/tb_leddc_scan_sched.sv
// Self-checking bench: random stimulus compared against a line-position model of the scheduler.
module tb_leddc_scan_sched;

   localparam int LINES  = 32;
   localparam int PWM    = 32;
   localparam int ADDR_W = 9;

   logic              GCK = 1'b0;
   logic              rst = 1'b0;
   logic              Vsync = 1'b0;
   logic              mode = 1'b0;
   logic              wr_req = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [15:0]       wr_data = '0;
   logic              wr_gnt, ram_cen, ram_wen, rd_valid, pwm_load, blank, frame_done;
   logic [ADDR_W-1:0] ram_addr;
   logic [15:0]       ram_din;
   logic [3:0]        rd_ch;
   logic [4:0]        pwm_cnt;
   logic [4:0]        line_idx;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // Model: position p within the current line (0..15 fetch, 16 load, 17.. display).
   bit m_active, m_fd, m_rv;
   int m_line, m_p, m_mode, m_rch;

   int first_fetch = -1;
   int first_fd    = -1;
   int vs_rise     = -1;

   leddc_scan_sched #(
      .SCANLINES(LINES), .CHANNELS(16), .PWM_CYCLES(PWM), .ADDR_W(ADDR_W)
   ) dut (
      .GCK(GCK), .rst(rst), .Vsync(Vsync), .mode(mode),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
      .rd_valid(rd_valid), .rd_ch(rd_ch), .pwm_load(pwm_load), .pwm_cnt(pwm_cnt),
      .blank(blank), .line_idx(line_idx), .frame_done(frame_done)
   );

   always #5 GCK = ~GCK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle=%0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_fd = 0; m_rv = 0;
      m_line = 0; m_p = 0; m_mode = 0; m_rch = 0;
   endtask

   function automatic int period_of(input int md);
      return 17 + PWM * (1 + md);
   endfunction

   task automatic model_advance();
      bit fetch, eof;
      fetch = m_active && m_p < 16;
      m_rv  = fetch;
      m_rch = m_p;
      m_fd  = 0;
      if (m_active && m_p == 16) m_mode = int'(mode);
      eof = m_active && (m_p == period_of(m_mode) - 1) && (m_line == LINES - 1);
      if (!Vsync) begin
         m_active = 0; m_line = 0; m_p = 0; m_fd = eof;
      end else if (!m_active) begin
         m_active = 1; m_line = 0; m_p = 0;
      end else begin
         m_p++;
         if (m_p == period_of(m_mode)) begin
            m_p  = 0;
            m_fd = eof;
            m_line = (m_line + 1) % LINES;
         end
      end
   endtask

   task automatic check_outputs();
      bit fetch, disp, wgrant;
      fetch  = m_active && m_p < 16;
      disp   = m_active && m_p >= 17;
      wgrant = wr_req && !fetch;
      check("wr_gnt",   wr_gnt,   wgrant);
      check("ram_cen",  ram_cen,  !(fetch || wr_req));
      check("ram_wen",  ram_wen,  !wgrant);
      check("ram_addr", ram_addr, fetch ? m_line * 16 + m_p : (wgrant ? int'(wr_addr) : 0));
      check("ram_din",  ram_din,  wgrant ? wr_data : 16'h0);
      check("pwm_load", pwm_load, m_active && m_p == 16);
      check("blank",    blank,    !disp);
      check("pwm_cnt",  pwm_cnt,  disp ? (m_p - 17) % PWM : 0);
      check("line_idx", line_idx, m_active ? m_line : 0);
      check("frame_done", frame_done, m_fd);
      check("rd_valid", rd_valid, m_rv);
      if (m_rv) check("rd_ch", rd_ch, m_rch);
   endtask

   task automatic check_reset_values();
      check("rst_blank", blank, 1);        check("rst_ram_cen", ram_cen, 1);
      check("rst_ram_wen", ram_wen, 1);    check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_din", ram_din, 0);    check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_ch", rd_ch, 0);        check("rst_pwm_load", pwm_load, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_line_idx", line_idx, 0);  check("rst_pwm_cnt", pwm_cnt, 0);
      check("rst_wr_gnt", wr_gnt, 0);
   endtask

   task automatic step(input bit r, input bit vs, input bit md, input bit wq,
                       input logic [ADDR_W-1:0] wa, input logic [15:0] wd);
      @(negedge GCK);
      if (vs && !Vsync && vs_rise < 0) vs_rise = cyc;
      rst = r; Vsync = vs; mode = md; wr_req = wq; wr_addr = wa; wr_data = wd;
      if (r) model_reset();
      #1;
      check_outputs();
      if (!ram_cen && ram_wen && first_fetch < 0) first_fetch = cyc;
      if (frame_done && first_fd < 0) first_fd = cyc;
      @(posedge GCK);
      if (r) model_reset(); else model_advance();
      cyc++;
   endtask

   task automatic rand_step(input bit vs, input bit md);
      step(0, vs, md, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 511)),
           16'($urandom_range(0, 65535)));
   endtask

   initial begin
      int guard;
      int drop;
      model_reset();
      #1 rst = 1'b1;
      #1 check_reset_values();
      step(1, 0, 0, 0, '0, '0);
      step(0, 0, 0, 0, '0, '0);

      // Full frame in mode 0 with the refill writer hammering one address.
      first_fetch = -1; first_fd = -1; vs_rise = -1;
      for (int i = 0; i < 1568 + 40; i++) step(0, 1, 0, 1, 9'h1F0, 16'hA5C3);
      check("vsync_to_fetch", first_fetch - vs_rise, 1);
      check("frame_period", first_fd - first_fetch, 32 * 49);

      // Two display windows per line.
      for (int i = 0; i < 3 * 81 + 10; i++) rand_step(1, 1);

      // Random mode, writer traffic and occasional Vsync drops.
      drop = 0;
      for (int i = 0; i < 3000; i++) begin
         if (drop == 0 && $urandom_range(0, 299) == 0) drop = $urandom_range(1, 5);
         rand_step(drop == 0, 1'($urandom_range(0, 1)));
         if (drop > 0) drop--;
      end

      // Restart a frame, then drop Vsync during the display window of line 5.
      step(0, 0, 0, 0, '0, '0);
      guard = 0;
      while (!(m_active && m_line == 5 && m_p == 30) && guard < 600) begin
         rand_step(1, 0);
         guard++;
      end
      check("reach_line5_display", guard < 600, 1);
      step(0, 0, 0, 0, '0, '0);
      step(0, 0, 0, 0, '0, '0);
      for (int i = 0; i < 40; i++) rand_step(1, 0);

      // Reset pulse while the channel-7 read is being issued.
      step(0, 0, 0, 0, '0, '0);
      guard = 0;
      while (!(m_active && m_p == 7) && guard < 100) begin
         step(0, 1, 0, 0, '0, '0);
         guard++;
      end
      check("reach_fetch_ch7", guard < 100, 1);
      @(negedge GCK);
      rst = 1'b1; wr_req = 1'b0;
      model_reset();
      #1 check_reset_values();
      @(posedge GCK);
      cyc++;
      step(1, 1, 0, 0, '0, '0);
      for (int i = 0; i < 60; i++) rand_step(1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
